// File: rtl/debounce_array_if.sv
`default_nettype none
// ============================================================================
// Module   : debounce_array_if
// Brief    : Pin-side and user-side signal bundle of the debounce array.
// Revision : 1.0
// ============================================================================
interface debounce_array_if #(
    parameter int NUM_CH = 4
);
    logic [NUM_CH-1:0] i_Bouncy;
    logic [NUM_CH-1:0] o_Debounced;
    logic [NUM_CH-1:0] o_Rise;
    logic [NUM_CH-1:0] o_Fall;
    logic [NUM_CH-1:0] o_Held;

    modport master (
        output i_Bouncy,
        input  o_Debounced,
        input  o_Rise,
        input  o_Fall,
        input  o_Held
    );

    modport slave (
        input  i_Bouncy,
        output o_Debounced,
        output o_Rise,
        output o_Fall,
        output o_Held
    );
endinterface
`default_nettype wire

// File: rtl/debounce_array.sv
`default_nettype none
// ============================================================================
// Module   : debounce_array
// Brief    : NUM_CH independent switch debouncers with rise/fall/long-press pulses.
// Revision : 1.0
// ============================================================================
module debounce_array #(
    parameter int NUM_CH         = 4,
    parameter int DEBOUNCE_LIMIT = 20,
    parameter int SYNC_STAGES    = 2,
    parameter int HOLD_LIMIT     = 0,
    parameter int RESET_LEVEL    = 0
) (
    input  wire logic        i_Clk,
    input  wire logic        i_Rst,
    debounce_array_if.slave  bus
);

    localparam int            CW        = $clog2(DEBOUNCE_LIMIT);
    localparam logic [CW-1:0] C_CNT_MAX = CW'(DEBOUNCE_LIMIT - 1);
    localparam logic          C_RST_LVL = (RESET_LEVEL != 0);

    logic [SYNC_STAGES-1:0] sync_q [NUM_CH];
    logic [CW-1:0]          cnt_q  [NUM_CH];
    logic [CW-1:0]          cnt_d  [NUM_CH];
    logic [NUM_CH-1:0]      deb_q,  deb_d;
    logic [NUM_CH-1:0]      rise_q, rise_d;
    logic [NUM_CH-1:0]      fall_q, fall_d;
    logic [NUM_CH-1:0]      w_sync;

    always_ff @(posedge i_Clk) begin
        for (int n = 0; n < NUM_CH; n++) begin
            if (i_Rst) begin
                sync_q[n] <= {SYNC_STAGES{C_RST_LVL}};
            end else begin
                sync_q[n] <= {sync_q[n][SYNC_STAGES-2:0], bus.i_Bouncy[n]};
            end
        end
    end

    always_comb begin
        for (int n = 0; n < NUM_CH; n++) begin
            w_sync[n] = sync_q[n][SYNC_STAGES-1];
        end
    end

    // Any cycle where the synchronised input agrees with the output restarts the count.
    always_comb begin
        deb_d  = deb_q;
        rise_d = '0;
        fall_d = '0;
        for (int n = 0; n < NUM_CH; n++) begin
            cnt_d[n] = '0;
            if (w_sync[n] != deb_q[n]) begin
                if (cnt_q[n] == C_CNT_MAX) begin
                    deb_d[n]  = w_sync[n];
                    rise_d[n] = w_sync[n];
                    fall_d[n] = ~w_sync[n];
                end else begin
                    cnt_d[n] = cnt_q[n] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            deb_q  <= {NUM_CH{C_RST_LVL}};
            rise_q <= '0;
            fall_q <= '0;
            for (int n = 0; n < NUM_CH; n++) begin
                cnt_q[n] <= '0;
            end
        end else begin
            deb_q  <= deb_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
            for (int n = 0; n < NUM_CH; n++) begin
                cnt_q[n] <= cnt_d[n];
            end
        end
    end

    assign bus.o_Debounced = deb_q;
    assign bus.o_Rise      = rise_q;
    assign bus.o_Fall      = fall_q;

    generate
        if (HOLD_LIMIT > 0) begin : g_hold
            localparam int            HW         = $clog2(HOLD_LIMIT + 1);
            localparam logic [HW-1:0] C_HOLD_MAX = HW'(HOLD_LIMIT);

            logic [HW-1:0]     hold_q [NUM_CH];
            logic [HW-1:0]     hold_d [NUM_CH];
            logic [NUM_CH-1:0] held_q, held_d;

            // Counter saturates at HOLD_LIMIT so each press yields a single pulse.
            always_comb begin
                held_d = '0;
                for (int n = 0; n < NUM_CH; n++) begin
                    hold_d[n] = '0;
                    if (deb_q[n]) begin
                        if (hold_q[n] < C_HOLD_MAX) begin
                            hold_d[n] = hold_q[n] + 1'b1;
                            held_d[n] = (hold_q[n] == C_HOLD_MAX - 1'b1);
                        end else begin
                            hold_d[n] = hold_q[n];
                        end
                    end
                end
            end

            always_ff @(posedge i_Clk) begin
                if (i_Rst) begin
                    held_q <= '0;
                    for (int n = 0; n < NUM_CH; n++) begin
                        hold_q[n] <= '0;
                    end
                end else begin
                    held_q <= held_d;
                    for (int n = 0; n < NUM_CH; n++) begin
                        hold_q[n] <= hold_d[n];
                    end
                end
            end

            assign bus.o_Held = held_q;
        end else begin : g_no_hold
            assign bus.o_Held = '0;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_debounce_array.sv
`default_nettype none
// ============================================================================
// Module   : tb_debounce_array
// Brief    : Directed self-checking bench for debounce_array (two configurations).
// Revision : 1.0
// ============================================================================
module tb_debounce_array;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    debounce_array_if #(.NUM_CH(4)) ifa ();
    debounce_array_if #(.NUM_CH(4)) ifb ();

    debounce_array #(
        .NUM_CH(4), .DEBOUNCE_LIMIT(4), .SYNC_STAGES(2),
        .HOLD_LIMIT(10), .RESET_LEVEL(0)
    ) u_dut_a (
        .i_Clk (clk),
        .i_Rst (rst),
        .bus   (ifa.slave)
    );

    debounce_array #(
        .NUM_CH(4), .DEBOUNCE_LIMIT(4), .SYNC_STAGES(2),
        .HOLD_LIMIT(0), .RESET_LEVEL(1)
    ) u_dut_b (
        .i_Clk (clk),
        .i_Rst (rst),
        .bus   (ifb.slave)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Each step lands on the falling edge after one more rising edge.
    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        ifa.i_Bouncy = 4'b0000;
        ifb.i_Bouncy = 4'b1111;
        rst = 1'b1;
        step(3);
        check("rst_deb_a",  ifa.o_Debounced, 4'b0000);
        check("rst_rise_a", ifa.o_Rise,      4'b0000);
        check("rst_fall_a", ifa.o_Fall,      4'b0000);
        check("rst_held_a", ifa.o_Held,      4'b0000);
        check("rst_deb_b",  ifb.o_Debounced, 4'b1111);
        check("rst_rise_b", ifb.o_Rise,      4'b0000);
        check("rst_fall_b", ifb.o_Fall,      4'b0000);
        rst = 1'b0;
        step(3);
        check("idle_deb_a", ifa.o_Debounced, 4'b0000);
        check("idle_rise_a", ifa.o_Rise, 4'b0000);

        // Clean rise on ch0: update at edge 5.
        ifa.i_Bouncy = 4'b0001;
        for (int i = 0; i < 5; i++) begin
            step(1);
            check("t1_wait_deb",  ifa.o_Debounced, 4'b0000);
            check("t1_wait_rise", ifa.o_Rise,      4'b0000);
            check("t1_b_rise",    ifb.o_Rise,      4'b0000);
        end
        step(1);
        check("t1_deb",  ifa.o_Debounced, 4'b0001);
        check("t1_rise", ifa.o_Rise,      4'b0001);
        check("t1_fall", ifa.o_Fall,      4'b0000);
        step(1);
        check("t1_rise_off", ifa.o_Rise,      4'b0000);
        check("t1_deb_hold", ifa.o_Debounced, 4'b0001);

        // Glitch on ch1: high 3, low 1, then steady high.
        ifa.i_Bouncy = 4'b0011;
        step(3);
        ifa.i_Bouncy = 4'b0001;
        step(1);
        ifa.i_Bouncy = 4'b0011;
        for (int i = 0; i < 5; i++) begin
            step(1);
            check("t2_wait_deb",  ifa.o_Debounced, 4'b0001);
            check("t2_wait_rise", ifa.o_Rise,      4'b0000);
        end
        step(1);
        check("t2_rise", ifa.o_Rise,      4'b0010);
        check("t2_deb",  ifa.o_Debounced, 4'b0011);
        step(1);
        check("t2_rise_off", ifa.o_Rise, 4'b0000);

        // Ch2 rises, settles, then falls.
        ifa.i_Bouncy = 4'b0111;
        step(6);
        check("t3_rise", ifa.o_Rise, 4'b0100);
        step(3);
        ifa.i_Bouncy = 4'b0011;
        for (int i = 0; i < 5; i++) begin
            step(1);
            check("t3_wait_fall", ifa.o_Fall,         4'b0000);
            check("t3_wait_deb2", ifa.o_Debounced[2], 1'b1);
            check("t3_wait_rise", ifa.o_Rise,         4'b0000);
        end
        step(1);
        check("t3_fall", ifa.o_Fall,      4'b0100);
        check("t3_deb",  ifa.o_Debounced, 4'b0011);
        check("t3_rise", ifa.o_Rise,      4'b0000);
        step(1);
        check("t3_fall_off", ifa.o_Fall, 4'b0000);

        // Long press on ch3, release, re-press.
        ifa.i_Bouncy = 4'b1011;
        step(6);
        check("t4_rise", ifa.o_Rise,      4'b1000);
        check("t4_deb",  ifa.o_Debounced, 4'b1011);
        for (int i = 0; i < 9; i++) begin
            step(1);
            check("t4_held_early", ifa.o_Held[3], 1'b0);
        end
        step(1);
        check("t4_held", ifa.o_Held[3], 1'b1);
        for (int i = 0; i < 20; i++) begin
            step(1);
            check("t4_held_once", ifa.o_Held[3], 1'b0);
        end
        ifa.i_Bouncy = 4'b0011;
        step(6);
        check("t4_fall", ifa.o_Fall, 4'b1000);
        ifa.i_Bouncy = 4'b1011;
        step(6);
        check("t4_rise2", ifa.o_Rise, 4'b1000);
        for (int i = 0; i < 9; i++) begin
            step(1);
            check("t4_held2_early", ifa.o_Held[3], 1'b0);
        end
        step(1);
        check("t4_held2", ifa.o_Held[3], 1'b1);
        step(1);
        check("t4_held2_off", ifa.o_Held[3], 1'b0);

        // Ch0 and ch3 change together.
        ifa.i_Bouncy = 4'b0010;
        for (int i = 0; i < 5; i++) begin
            step(1);
            check("t5_wait_fall", ifa.o_Fall, 4'b0000);
        end
        step(1);
        check("t5_fall",      ifa.o_Fall,      4'b1001);
        check("t5_fall_rise", ifa.o_Rise,      4'b0000);
        check("t5_fall_deb",  ifa.o_Debounced, 4'b0010);
        ifa.i_Bouncy = 4'b1011;
        step(5);
        step(1);
        check("t5_rise",      ifa.o_Rise,      4'b1001);
        check("t5_rise_fall", ifa.o_Fall,      4'b0000);
        check("t5_rise_deb",  ifa.o_Debounced, 4'b1011);

        // Reset while ch2 count is 3 of 4.
        ifa.i_Bouncy = 4'b1111;
        step(5);
        rst = 1'b1;
        step(1);
        check("t6_rst_deb",  ifa.o_Debounced, 4'b0000);
        check("t6_rst_rise", ifa.o_Rise,      4'b0000);
        check("t6_rst_fall", ifa.o_Fall,      4'b0000);
        check("t6_rst_held", ifa.o_Held,      4'b0000);
        check("t6_rst_deb_b", ifb.o_Debounced, 4'b1111);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(1);
            check("t6_wait_deb",  ifa.o_Debounced, 4'b0000);
            check("t6_wait_rise", ifa.o_Rise,      4'b0000);
        end
        step(1);
        check("t6_deb",  ifa.o_Debounced, 4'b1111);
        check("t6_rise", ifa.o_Rise,      4'b1111);

        // Idle-high configuration never pulses.
        for (int i = 0; i < 8; i++) begin
            step(1);
            check("b_deb",  ifb.o_Debounced, 4'b1111);
            check("b_rise", ifb.o_Rise,      4'b0000);
            check("b_fall", ifb.o_Fall,      4'b0000);
            check("b_held", ifb.o_Held,      4'b0000);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/debounce_array.md
Name: debounce_array

Overview:
Multi-channel successor to the single-input debounce filter. Debounces NUM_CH independent switch/button inputs with a per-channel stability counter. Each channel has a built-in metastability synchroniser, registered rise/fall pulses, and an optional long-press pulse. Sits between board pins and user logic, such as LED toggling or state-machine triggers.

Parameters:
NUM_CH, 4, number of independent input channels (>=1)
DEBOUNCE_LIMIT, 20, consecutive stable cycles needed before o_Debounced updates (>=2)
SYNC_STAGES, 2, synchroniser flops per channel (>=2)
HOLD_LIMIT, 0, cycles o_Debounced must stay 1 before o_Held pulses; 0 disables the hold logic (o_Held tied 0)
RESET_LEVEL, 0, idle level of the inputs; reset value of the synchronisers and o_Debounced (0 or 1, applied to all channels)

Ports:
i_Clk  input  1  system clock
i_Rst  input  1  synchronous, active-high reset
i_Bouncy  input  NUM_CH  raw asynchronous switch inputs, bit n = channel n
o_Debounced  output  NUM_CH  debounced level per channel
o_Rise  output  NUM_CH  one-cycle pulse when o_Debounced[n] goes 0->1
o_Fall  output  NUM_CH  one-cycle pulse when o_Debounced[n] goes 1->0
o_Held  output  NUM_CH  one-cycle pulse after HOLD_LIMIT cycles of o_Debounced[n]=1

Behaviour:
- One clock (i_Clk); reset is synchronous and active-high (i_Rst). All logic is clocked on the i_Clk rising edge, with no other clocks.
- Reset (i_Rst=1 at a rising edge):
  - synchroniser flops and o_Debounced = RESET_LEVEL
  - all counters = 0
  - o_Rise, o_Fall, o_Held = 0
- Reset overrides everything, including an update due on the same edge. Reset mid-count discards progress.
- Channels are fully independent. Each has its own synchroniser, stability counter of width $clog2(DEBOUNCE_LIMIT) and hold counter of width $clog2(HOLD_LIMIT+1).
- Synchroniser: a SYNC_STAGES-deep shift register per channel. s[n] is the last stage.
- Stability counter, per channel, each edge:
  - s==o_Debounced: count <= 0, no update.
  - s!=o_Debounced and count==DEBOUNCE_LIMIT-1: o_Debounced <= s; count <= 0; o_Rise or o_Fall <= 1 for this cycle only.
  - s!=o_Debounced otherwise: count <= count+1.
- A single cycle of s==o_Debounced restarts the count. A glitch shorter than DEBOUNCE_LIMIT cycles never propagates.
- Latency: a clean input change is first sampled at edge 0. o_Debounced and the edge pulse change at edge SYNC_STAGES+DEBOUNCE_LIMIT-1, which is the (SYNC_STAGES+DEBOUNCE_LIMIT)-th edge. The edge pulse is coincident with the o_Debounced transition.
- o_Rise and o_Fall are never both 1 on one channel. Each is high for exactly one cycle per transition. They are registered, with no combinational path from inputs.
- Hold logic (HOLD_LIMIT>0), per channel:
  - o_Debounced==0: hold count <= 0.
  - else if hold count < HOLD_LIMIT: hold count <= hold count+1, and o_Held <= 1 on the edge where the count becomes HOLD_LIMIT.
  - else saturate, with no further pulses.
- The first edge with o_Debounced=1 counts as 1. o_Held therefore pulses HOLD_LIMIT cycles after o_Rise, exactly once per press. Release and re-press rearm it.
- Simultaneous events on different channels are handled in parallel, with no priority or arbitration.
- Inputs held at RESET_LEVEL through and after reset produce no pulses.

Test Plan:
1. NUM_CH=4, DEBOUNCE_LIMIT=4, SYNC_STAGES=2. Reset, then set i_Bouncy[0] 0->1 (first sampled at edge 0) and hold -> o_Debounced[0]=1 and o_Rise[0]=1 exactly at edge 5, for one cycle; other channels stay 0 with no pulses.
2. Same config. Toggle i_Bouncy[1] high for 3 cycles, low for 1, then high steady -> no change during the glitch; o_Rise[1] occurs 5 edges after the final rising sample.
3. Channel 2 high and stable, then drop to 0 -> o_Fall[2] pulses once at the 6th edge after the low sample; o_Rise[2] stays 0 throughout.
4. HOLD_LIMIT=10. Hold channel 3 high -> o_Held[3] pulses once, 10 cycles after o_Rise[3], and never again while held. Release and re-press -> pulses again.
5. Channels 0 and 3 change on the same cycle -> both update on the same edge with independent pulses.
6. Assert i_Rst when a channel's count is 3 of 4 -> o_Debounced stays RESET_LEVEL and no pulse. After release, a full 6-edge latency is needed to update. RESET_LEVEL=1 with inputs held high -> no pulses.
